// File: rtl/obstacle_pool.sv
// Pool of NUM_SLOTS obstacle slots with programmable scroll speed and randomised spawn spacing.
// Every output is driven straight from a register; positions use the renderers' CONV-scaled units.
module obstacle_pool #(
    parameter int NUM_SLOTS = 4,
    parameter int CONV      = 2,
    parameter int SPAWN_POS = 159,
    parameter int MIN_GAP   = 40,
    parameter int SPEED_MAX = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_game_start,
    input  logic                            i_game_frozen,
    input  logic                            i_game_tick,
    input  logic                            i_speed_up,
    input  logic [7:0]                      i_rng,
    output logic [NUM_SLOTS*(10-CONV)-1:0]  o_obs_pos,
    output logic [NUM_SLOTS*3-1:0]          o_obs_type,
    output logic [NUM_SLOTS-1:0]            o_obs_active,
    output logic [2:0]                      o_speed
);
    localparam int                POS_W   = 10 - CONV;
    localparam logic [POS_W-1:0]  POS_OFF = {POS_W{1'b1}};
    localparam logic [POS_W-1:0]  SPAWN_P = POS_W'(SPAWN_POS);
    localparam logic [7:0]        GAP_MIN = 8'(MIN_GAP);
    localparam logic [2:0]        SPD_MAX = 3'(SPEED_MAX);

    logic [NUM_SLOTS*POS_W-1:0] r_pos, w_pos;
    logic [NUM_SLOTS*3-1:0]     r_type, w_type;
    logic [NUM_SLOTS-1:0]       r_act, w_act;
    logic [2:0]                 r_speed, w_speed;
    logic [7:0]                 r_gap, w_gap;
    logic [7:0]                 r_thr, w_thr;
    logic [8:0]                 w_sum;
    logic [7:0]                 w_g;
    logic                       w_free_found;
    int                         w_free_idx;

    // Next-state: start clears, frozen holds, otherwise speed-up and tick (tick uses pre-update speed/actives)
    always_comb begin
        w_pos        = r_pos;
        w_type       = r_type;
        w_act        = r_act;
        w_speed      = r_speed;
        w_gap        = r_gap;
        w_thr        = r_thr;
        w_sum        = {1'b0, r_gap} + {6'b000000, r_speed};
        w_g          = w_sum[8] ? 8'hFF : w_sum[7:0];
        w_free_found = 1'b0;
        w_free_idx   = 0;
        // Descending scan leaves the lowest free index; slots freed this tick are not candidates
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (!r_act[k]) begin
                w_free_found = 1'b1;
                w_free_idx   = k;
            end else begin
                w_free_found = w_free_found;
            end
        end
        if (i_game_start) begin
            w_pos   = {NUM_SLOTS*POS_W{1'b1}};
            w_type  = {NUM_SLOTS*3{1'b0}};
            w_act   = {NUM_SLOTS{1'b0}};
            w_speed = 3'd1;
            w_gap   = 8'd0;
            w_thr   = GAP_MIN;
        end else if (!i_game_frozen) begin
            if (i_speed_up) begin
                w_speed = (r_speed >= SPD_MAX) ? SPD_MAX : r_speed + 3'd1;
            end else begin
                w_speed = r_speed;
            end
            if (i_game_tick) begin
                for (int k = 0; k < NUM_SLOTS; k++) begin
                    if (!r_act[k]) begin
                        w_act[k] = 1'b0;
                    end else if (r_pos[k*POS_W +: POS_W] < POS_W'(r_speed)) begin
                        w_act[k]               = 1'b0;
                        w_pos[k*POS_W +: POS_W] = POS_OFF;
                        w_type[k*3 +: 3]        = 3'd0;
                    end else begin
                        w_pos[k*POS_W +: POS_W] = r_pos[k*POS_W +: POS_W] - POS_W'(r_speed);
                    end
                end
                if ((w_g >= r_thr) && w_free_found) begin
                    w_act[w_free_idx]                = 1'b1;
                    w_pos[w_free_idx*POS_W +: POS_W] = SPAWN_P;
                    w_type[w_free_idx*3 +: 3]        = i_rng[7:5];
                    w_gap                            = 8'd0;
                    w_thr                            = GAP_MIN + {3'b000, i_rng[4:0]};
                end else begin
                    w_gap = w_g;
                end
            end else begin
                w_gap = r_gap;
            end
        end else begin
            w_gap = r_gap;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos   <= {NUM_SLOTS*POS_W{1'b1}};
            r_type  <= {NUM_SLOTS*3{1'b0}};
            r_act   <= {NUM_SLOTS{1'b0}};
            r_speed <= 3'd1;
            r_gap   <= 8'd0;
            r_thr   <= GAP_MIN;
        end else begin
            r_pos   <= w_pos;
            r_type  <= w_type;
            r_act   <= w_act;
            r_speed <= w_speed;
            r_gap   <= w_gap;
            r_thr   <= w_thr;
        end
    end

    assign o_obs_pos    = r_pos;
    assign o_obs_type   = r_type;
    assign o_obs_active = r_act;
    assign o_speed      = r_speed;

endmodule
